// File: rtl/flit_packetizer.sv
// Packetizer: turns a packet request plus its payload words into head/body/tail
// flits for a credit-flow-controlled downstream FIFO. rst_n is active-high here.
module flit_packetizer #(
  parameter logic [3:0] SRC_ID = 4'h0,
  parameter int         DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pkt_valid,
  output logic                     pkt_ready,
  input  logic [3:0]               pkt_dest,
  input  logic [3:0]               pkt_len,
  input  logic                     pld_valid,
  output logic                     pld_ready,
  input  logic [29:0]              pld_data,
  output logic [31:0]              flit_out,
  output logic                     flit_wr_en,
  input  logic                     credit_ret,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     cred_err
);

  // state   | meaning
  // IDLE    | waiting for a packet request
  // HEAD    | head flit pending, waits for a credit
  // PAYLOAD | forwarding payload words as body/tail flits
  // ZTAIL   | zero-length packet, empty tail pending
  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, ZTAIL} state_t;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  state_t          state_q, state_d;
  logic [3:0]      dest_q, len_q, rem_q;
  logic [31:0]     flit_q, flit_d;
  logic            wr_q;
  logic [CW-1:0]   cred_q, cred_d;
  logic            err_q, err_d;
  logic            has_cred, emit, pkt_hs, pld_hs;

  assign has_cred = (cred_q != '0);
  assign pkt_hs   = pkt_valid && pkt_ready;
  assign pld_hs   = pld_valid && pld_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_valid) state_d = HEAD;
      HEAD:    if (has_cred) state_d = (len_q != 4'd0) ? PAYLOAD : ZTAIL;
      PAYLOAD: if (pld_valid && has_cred && rem_q <= 4'd1) state_d = IDLE;
      ZTAIL:   if (has_cred) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_ready = (state_q == IDLE);
    pld_ready = (state_q == PAYLOAD) && has_cred;
    emit      = 1'b0;
    flit_d    = flit_q;
    case (state_q)
      HEAD: begin
        emit   = has_cred;
        flit_d = {2'b01, 14'b0, SRC_ID, dest_q, 4'b0, len_q};
      end
      PAYLOAD: begin
        emit   = pld_valid && has_cred;
        flit_d = {(rem_q > 4'd1) ? 2'b10 : 2'b11, pld_data};
      end
      ZTAIL: begin
        emit   = has_cred;
        flit_d = {2'b11, 30'b0};
      end
      default: ;
    endcase
    if (!emit) flit_d = flit_q;
  end

  // A return arriving while already full has no flit to match; clamp and flag it.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    case ({emit, credit_ret})
      2'b10: cred_d = cred_q - 1'b1;
      2'b01: begin
        if (cred_q == CRED_MAX) err_d  = 1'b1;
        else                    cred_d = cred_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dest_q <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      flit_q <= '0;
      wr_q   <= 1'b0;
      cred_q <= CRED_MAX;
      err_q  <= 1'b0;
    end else begin
      if (pkt_hs) begin
        dest_q <= pkt_dest;
        len_q  <= pkt_len;
        rem_q  <= pkt_len;
      end else if (pld_hs) begin
        rem_q  <= rem_q - 1'b1;
      end
      flit_q <= flit_d;
      wr_q   <= emit;
      cred_q <= cred_d;
      err_q  <= err_d;
    end
  end

  assign flit_out   = flit_q;
  assign flit_wr_en = wr_q;
  assign credits    = cred_q;
  assign cred_err   = err_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized and directed bench for flit_packetizer; expected flits, credits and
// handshake readiness come from a queue-based packet model.
module tb_flit_packetizer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pkt_valid = 1'b0, pld_valid = 1'b0, credit_ret = 1'b0;
  logic [3:0]  pkt_dest = '0, pkt_len = '0;
  logic [29:0] pld_data = '0;
  logic        pkt_ready, pld_ready, flit_wr_en, cred_err;
  logic [31:0] flit_out;
  logic [3:0]  credits;

  flit_packetizer #(.SRC_ID(4'h3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .flit_out(flit_out), .flit_wr_en(flit_wr_en),
    .credit_ret(credit_ret), .credits(credits), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [29:0] pq[$];
  logic [31:0] seen[$];
  int          seen_cyc[$];
  int          exp_cred = DEPTH, occ = 0, cyc = 0;
  bit          exp_err = 0, exp_emit = 0, ret_prev = 0, zero_len = 0, seq_pld = 0, pld_hi = 0;
  logic [31:0] last_flit = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A packet, from the outside, is just its ordered list of flits.
  task automatic enqueue(input logic [3:0] d, input logic [3:0] l);
    logic [29:0] w;
    q.push_back({2'b01, 14'b0, 4'h3, d, 4'b0, l});
    zero_len = (l == 0);
    if (l == 0) q.push_back({2'b11, 30'b0});
    for (int i = 0; i < int'(l); i++) begin
      w = seq_pld ? 30'(i + 1) : 30'($urandom);
      pq.push_back(w);
      q.push_back({(i == int'(l) - 1) ? 2'b11 : 2'b10, w});
    end
  endtask

  task automatic step(input bit pv, input logic [3:0] d, input logic [3:0] l,
                      input bit plv, input int rmode);
    bit emit_n, ret, in_pld;
    int nc;
    @(negedge clk);
    cyc++;
    chk("wr_en", 32'(flit_wr_en), 32'(exp_emit));
    if (flit_wr_en) begin
      seen.push_back(flit_out);
      seen_cyc.push_back(cyc);
    end
    if (exp_emit && q.size() > 0) begin
      last_flit = q.pop_front();
      chk("flit", flit_out, last_flit);
      occ++;
    end else begin
      chk("flit_hold", flit_out, last_flit);
    end
    nc = exp_cred - int'(exp_emit) + int'(ret_prev);
    if (nc > DEPTH) begin
      nc = DEPTH;
      exp_err = 1;
    end
    exp_cred = nc;
    chk("credits", 32'(credits), 32'(exp_cred));
    chk("cred_err", 32'(cred_err), 32'(exp_err));
    chk("pkt_ready", 32'(pkt_ready), 32'(q.size() == 0));
    in_pld = (q.size() > 0) && (q[0][31:30] != 2'b01) && !zero_len;
    chk("pld_ready", 32'(pld_ready), 32'(in_pld && exp_cred != 0));
    if (pld_ready) pld_hi = 1;

    emit_n = 0;
    if (q.size() > 0 && exp_cred != 0) emit_n = in_pld ? plv : 1'b1;
    pld_valid = plv;
    pld_data  = (pq.size() > 0) ? pq[0] : 30'($urandom);
    if (emit_n && in_pld && pq.size() > 0) void'(pq.pop_front());
    pkt_valid = pv;
    pkt_dest  = d;
    pkt_len   = l;
    if (pv && q.size() == 0) enqueue(d, l);
    ret = 0;
    case (rmode)
      1: ret = (occ > 0) && ($urandom_range(1, 0) == 1);
      2: ret = 1;
      3: ret = (occ > 0);
      default: ret = 0;
    endcase
    if (ret && occ > 0) occ--;
    credit_ret = ret;
    exp_emit   = emit_n;
    ret_prev   = ret;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pkt_valid = 0; pld_valid = 0; credit_ret = 0;
    @(negedge clk);
    chk("rst_wr_en", 32'(flit_wr_en), 32'd0);
    chk("rst_flit", flit_out, 32'd0);
    chk("rst_credits", 32'(credits), 32'd8);
    chk("rst_cred_err", 32'(cred_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(); pq.delete();
    exp_cred = DEPTH; exp_err = 0; exp_emit = 0; ret_prev = 0;
    occ = 0; last_flit = '0; zero_len = 0;
    #1;
    chk("rel_pkt_ready", 32'(pkt_ready), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && occ == 0 && exp_cred == DEPTH && !exp_emit && !ret_prev) break;
      step(0, 4'h0, 4'h0, 1, 3);
    end
    step(0, 4'h0, 4'h0, 0, 0);
    chk("drain_credits", 32'(credits), 32'd8);
  endtask

  initial begin
    do_reset();

    // dest=5 len=2 with payloads 1,2
    seq_pld = 1;
    seen.delete(); seen_cyc.delete();
    step(1, 4'h5, 4'd2, 0, 0);
    for (int i = 0; i < 10 && seen.size() < 3; i++) step(0, 4'h0, 4'h0, 1, 0);
    chk("t2_count", 32'(seen.size()), 32'd3);
    chk("t2_head", seen[0], 32'h40003502);
    chk("t2_body", seen[1], 32'h80000001);
    chk("t2_tail", seen[2], 32'hC0000002);
    chk("t2_consec", 32'(seen_cyc[2] - seen_cyc[0]), 32'd2);
    chk("t2_credits", 32'(credits), 32'd5);

    // zero-length packet; payload offered the whole time must be ignored
    seen.delete(); pld_hi = 0;
    step(1, 4'hA, 4'd0, 1, 0);
    for (int i = 0; i < 10 && seen.size() < 2; i++) step(0, 4'h0, 4'h0, 1, 0);
    chk("t3_head", seen[0], 32'h40003A00);
    chk("t3_tail", seen[1], 32'hC0000000);
    chk("t3_pld_ready", 32'(pld_hi), 32'd0);
    chk("t3_credits", 32'(credits), 32'd3);
    seq_pld = 0;
    drain();

    // credit starvation on long packets
    seen.delete();
    for (int i = 0; i < 40; i++) step(1, 4'h1, 4'd15, 1, 0);
    chk("t4_count", 32'(seen.size()), 32'd8);
    chk("t4_credits", 32'(credits), 32'd0);
    chk("t4_pld_ready", 32'(pld_ready), 32'd0);
    chk("t4_wr_en", 32'(flit_wr_en), 32'd0);
    seen.delete();
    step(0, 4'h0, 4'h0, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 4'h0, 1, 0);
    chk("t4_one_more", 32'(seen.size()), 32'd1);
    chk("t4_credits2", 32'(credits), 32'd0);

    // emission and return in the same cycle at credits=1
    step(0, 4'h0, 4'h0, 1, 2);
    step(0, 4'h0, 4'h0, 1, 2);
    step(0, 4'h0, 4'h0, 0, 0);
    chk("t5_credits", 32'(credits), 32'd1);
    chk("t5_wr_en", 32'(flit_wr_en), 32'd1);
    drain();
    step(0, 4'h0, 4'h0, 0, 2);
    step(0, 4'h0, 4'h0, 0, 0);
    chk("t5_ovf_credits", 32'(credits), 32'd8);
    chk("t5_ovf_err", 32'(cred_err), 32'd1);
    do_reset();
    chk("t5_err_cleared", 32'(cred_err), 32'd0);

    // reset right after the head of a len=3 packet
    seen.delete();
    step(1, 4'h7, 4'd3, 0, 0);
    for (int i = 0; i < 10 && seen.size() < 1; i++) step(0, 4'h0, 4'h0, 0, 0);
    chk("t6_head", seen[0], 32'h40003703);
    do_reset();
    chk("t6_credits", 32'(credits), 32'd8);
    seen.delete();
    for (int i = 0; i < 10; i++) step(0, 4'h0, 4'h0, 1, 0);
    chk("t6_no_flits", 32'(seen.size()), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2, 0) == 0, 4'($urandom), 4'($urandom),
           $urandom_range(3, 0) != 0, 1);
    drain();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
